// File: rtl/power_monitor_pkg.sv
// rtl/power_monitor_pkg.sv - shared state encoding, fault codes and sample width for the power monitor
package power_monitor_pkg;

   localparam int SAMPLE_W = 12;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SETTLE    = 3'd1,
      ST_WAIT_DATA = 3'd2,
      ST_EVAL      = 3'd3,
      ST_FAULT     = 3'd4
   } state_e;

   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_OVER    = 2'b01;
   localparam logic [1:0] FC_UNDER   = 2'b10;
   localparam logic [1:0] FC_TIMEOUT = 2'b11;

endpackage

// File: rtl/pulse_edge_detect.sv
// rtl/pulse_edge_detect.sv - single-cycle rising-edge strobe for a clk-synchronous level
module pulse_edge_detect (
   input  logic clk,
   input  logic rstn,
   input  logic in,
   output logic rise
);

   logic prev_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= in;
      end
   end

   assign rise = in & ~prev_q;

endmodule

// File: rtl/power_monitor_ctrl.sv
// rtl/power_monitor_ctrl.sv - laser power monitor: pulse-timed ADC sampling, window check, sticky fault
// Optional peak hold enabled by defining POWER_MONITOR_PEAK_HOLD_EN.
module power_monitor_ctrl
   import power_monitor_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 200,
   parameter int FAULT_LIMIT    = 3
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                enable,
   input  logic                laser_pulse,
   input  logic                adc_data_valid,
   input  logic [15:0]         adc_data_value,
   input  logic [SAMPLE_W-1:0] thresh_hi,
   input  logic [SAMPLE_W-1:0] thresh_lo,
   input  logic                clear_fault,
   input  logic                clear_peak,
   output logic                adc_trigger,
   output logic [SAMPLE_W-1:0] last_value,
   output logic [SAMPLE_W-1:0] peak_value,
   output logic                fault,
   output logic [1:0]          fault_code,
   output logic [7:0]          missed_pulses
);

   localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  CONSEC_LIMIT = 8'(FAULT_LIMIT);

   state_e              state_q, state_d;
   logic [15:0]         tmr_q, tmr_d;
   logic [7:0]          consec_q, consec_d;
   logic [7:0]          missed_q, missed_d;
   logic                trig_q, trig_d;
   logic [SAMPLE_W-1:0] last_q, last_d;
   logic [1:0]          code_q, code_d;
   logic                laser_rise;
   logic                over, under;
   logic                unused_adc_msbs;

   pulse_edge_detect u_laser_edge (
      .clk  (clk),
      .rstn (rstn),
      .in   (laser_pulse),
      .rise (laser_rise)
   );

   assign unused_adc_msbs = ^adc_data_value[15:12];
   assign over  = last_q > thresh_hi;
   assign under = last_q < thresh_lo;

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      consec_d = consec_q;
      missed_d = missed_q;
      trig_d   = 1'b0;
      last_d   = last_q;
      code_d   = code_q;

      if (laser_rise && state_q != ST_IDLE && missed_q != 8'hFF) begin
         missed_d = missed_q + 8'd1;
      end
      if (clear_fault) begin
         missed_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable && laser_rise) begin
               state_d = ST_SETTLE;
               tmr_d   = '0;
            end
         end
         ST_SETTLE: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (tmr_q == SETTLE_LAST) begin
               trig_d  = 1'b1;
               tmr_d   = '0;
               state_d = ST_WAIT_DATA;
            end else begin
               tmr_d = tmr_q + 16'd1;
            end
         end
         ST_WAIT_DATA: begin
            // A sample arriving on the last allowed cycle still beats the timeout.
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (adc_data_valid) begin
               last_d  = adc_data_value[SAMPLE_W-1:0];
               state_d = ST_EVAL;
            end else if (tmr_q == TIMEOUT_LAST) begin
               code_d  = FC_TIMEOUT;
               state_d = ST_FAULT;
            end else begin
               tmr_d = tmr_q + 16'd1;
            end
         end
         ST_EVAL: begin
            state_d = ST_IDLE;
            if (enable) begin
               if (over || under) begin
                  consec_d = consec_q + 8'd1;
                  if (consec_q + 8'd1 == CONSEC_LIMIT) begin
                     code_d  = over ? FC_OVER : FC_UNDER;
                     state_d = ST_FAULT;
                  end
               end else begin
                  consec_d = '0;
               end
            end
         end
         ST_FAULT: begin
            if (clear_fault) begin
               code_d   = FC_NONE;
               consec_d = '0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         tmr_q    <= '0;
         consec_q <= '0;
         missed_q <= '0;
         trig_q   <= 1'b0;
         last_q   <= '0;
         code_q   <= FC_NONE;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         consec_q <= consec_d;
         missed_q <= missed_d;
         trig_q   <= trig_d;
         last_q   <= last_d;
         code_q   <= code_d;
      end
   end

`ifdef POWER_MONITOR_PEAK_HOLD_EN
   logic [SAMPLE_W-1:0] peak_q, peak_d;

   always_comb begin
      peak_d = peak_q;
      if (state_q == ST_EVAL && enable && last_q > peak_q) begin
         peak_d = last_q;
      end
      if (clear_peak) begin
         peak_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         peak_q <= '0;
      end else begin
         peak_q <= peak_d;
      end
   end

   assign peak_value = peak_q;
`else
   logic unused_clear_peak;
   assign unused_clear_peak = clear_peak;
   assign peak_value        = '0;
`endif

   assign adc_trigger   = trig_q;
   assign last_value    = last_q;
   assign fault         = (state_q == ST_FAULT);
   assign fault_code    = code_q;
   assign missed_pulses = missed_q;

endmodule
